// File: rtl/sodor5_tb_pkg.sv
// sodor5_tb_pkg: shared constants and feeder state type for the sodor5 harness
package sodor5_tb_pkg;
  localparam int WORD_SIZE = 32;
  localparam logic [WORD_SIZE-1:0] NOP_WORD = 32'h00000013;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} feeder_state_t;
endpackage

// File: rtl/imem_stream_feeder_prog_buf.sv
// prog_buf: program buffer, one synchronous write port and one async read port
module prog_buf #(
  parameter int DEPTH = 16,
  parameter int WORD_SIZE = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [WORD_SIZE-1:0] rdata
);
  logic [WORD_SIZE-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/imem_stream_feeder.sv
// imem_stream_feeder: streams a loaded program into the core, NOP-filling idle and drain cycles
module imem_stream_feeder #(
  parameter int DEPTH = 16,
  parameter int WORD_SIZE = sodor5_tb_pkg::WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] NOP_WORD = sodor5_tb_pkg::NOP_WORD,
  parameter int DRAIN_NOPS = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_valid,
  input  logic [AW-1:0]        load_addr,
  input  logic [WORD_SIZE-1:0] load_data,
  input  logic                 start,
  input  logic [AW:0]          len,
  input  logic                 loop_en,
  input  logic                 stop,
  input  logic                 hold,
  output logic [WORD_SIZE-1:0] instr,
  output logic [AW-1:0]        instr_idx,
  output logic                 is_prog,
  output logic                 busy,
  output logic                 done
);
  import sodor5_tb_pkg::*;
  localparam int CW = $clog2(DRAIN_NOPS + 2);
  feeder_state_t state, state_n;
  logic [AW-1:0] ptr, ptr_n, idx_n;
  logic [AW:0] len_q, len_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WORD_SIZE-1:0] rd_data, instr_n;
  logic loop_q, loop_n, prog_n, done_n, last;
  prog_buf #(.DEPTH(DEPTH), .WORD_SIZE(WORD_SIZE)) u_buf (
    .clk   (clk),
    .we    (load_valid && state == IDLE && !hold && reset),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (ptr),
    .rdata (rd_data)
  );
  assign busy = (state != IDLE);
  assign last = ({1'b0, ptr} == len_q - 1'b1);
  // ptr always names the next word to emit; cnt counts drain NOPs already emitted
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    len_n   = len_q;
    loop_n  = loop_q;
    cnt_n   = cnt;
    instr_n = NOP_WORD;
    idx_n   = '0;
    prog_n  = 1'b0;
    done_n  = 1'b0;
    if (hold) begin
      instr_n = instr;
      idx_n   = instr_idx;
      prog_n  = is_prog;
      done_n  = done;
    end else begin
      case (state)
        IDLE: if (start) begin
          len_n  = len;
          loop_n = loop_en;
          if (len == '0) begin
            state_n = DRAIN;
            cnt_n   = CW'(1);
          end else begin
            instr_n = rd_data;
            prog_n  = 1'b1;
            cnt_n   = '0;
            ptr_n   = (len == (AW+1)'(1)) ? '0 : AW'(1);
            state_n = (len == (AW+1)'(1) && !loop_en) ? DRAIN : RUN;
          end
        end
        RUN: if (stop) begin
          state_n = DRAIN;
          cnt_n   = CW'(1);
          ptr_n   = '0;
        end else begin
          instr_n = rd_data;
          idx_n   = ptr;
          prog_n  = 1'b1;
          ptr_n   = last ? '0 : ptr + 1'b1;
          state_n = (last && !loop_q) ? DRAIN : RUN;
          cnt_n   = '0;
        end
        DRAIN: if (cnt >= CW'(DRAIN_NOPS)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else cnt_n = cnt + 1'b1;
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      len_q     <= '0;
      loop_q    <= 1'b0;
      cnt       <= '0;
      instr     <= NOP_WORD;
      instr_idx <= '0;
      is_prog   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      len_q     <= len_n;
      loop_q    <= loop_n;
      cnt       <= cnt_n;
      instr     <= instr_n;
      instr_idx <= idx_n;
      is_prog   <= prog_n;
      done      <= done_n;
    end
endmodule
